// File: rtl/mem_stage.sv
// LEGv8 pipeline memory stage: EX/MEM register, request/acknowledge data-memory handshake
// with back-pressure to execute, branch resolution and a sticky memory-timeout flag.
module mem_stage #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         Branch_E,
    input  logic         memRead_E,
    input  logic         memWrite_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,
    output logic         stall_E,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         valid_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic         mem_error
);

    typedef enum logic {StIdle, StReq} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         branch_q, branch_d;
    logic         zero_q, zero_d;
    logic         we_q, we_d;
    logic         err_q, err_d;
    logic [N-1:0] alu_q, alu_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] pcb_q, pcb_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         capture;

    // Stall is a pure state decode so dm_ack never reaches execute combinationally.
    assign stall_E = (state_q == StReq);
    assign capture = valid_E & ~stall_E;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        branch_d = branch_q;
        zero_d   = zero_q;
        we_d     = we_q;
        err_d    = err_q;
        alu_d    = alu_q;
        wdata_d  = wdata_q;
        pcb_d    = pcb_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    branch_d = Branch_E;
                    zero_d   = zero_E;
                    alu_d    = aluResult_E;
                    wdata_d  = writeData_E;
                    pcb_d    = PCBranch_E;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    if (memRead_E | memWrite_E) begin
                        state_d = StReq;
                        we_d    = memWrite_E;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (dm_ack) begin
                    rdata_d = we_q ? '0 : dm_rdata;
                    valid_d = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            branch_q <= 1'b0;
            zero_q   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            alu_q    <= '0;
            wdata_q  <= '0;
            pcb_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            branch_q <= branch_d;
            zero_q   <= zero_d;
            we_q     <= we_d;
            err_q    <= err_d;
            alu_q    <= alu_d;
            wdata_q  <= wdata_d;
            pcb_q    <= pcb_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dm_req      = (state_q == StReq);
    assign dm_we       = we_q;
    assign dm_addr     = alu_q;
    assign dm_wdata    = wdata_q;
    assign valid_M     = valid_q;
    assign aluResult_M = alu_q;
    assign readData_M  = rdata_q;
    assign PCBranch_M  = pcb_q;
    assign PCSrc_M     = valid_q & branch_q & zero_q;
    assign mem_error   = err_q;

endmodule
